// File: rtl/bid_argmax_pipe.sv
// Pipelined argmax over N_BIDS masked bids. Reports the winner index, the winning price and the
// second price. One input register stage feeds a registered binary tournament tree.
module bid_argmax_pipe #(
  parameter  int N_BIDS = 10,
  parameter  int BW     = 16,
  localparam int IDX_W  = $clog2(N_BIDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_BIDS*BW-1:0] in_bids,
  input  logic [N_BIDS-1:0]    in_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic [BW-1:0]        out_max,
  output logic [BW-1:0]        out_second,
  output logic                 out_none
);

  localparam int L  = $clog2(N_BIDS);
  localparam int NL = 1 << L;

  typedef struct packed {
    logic             en;
    logic [IDX_W-1:0] idx;
    logic [BW-1:0]    top;
    logic [BW-1:0]    sec;
  } ent_t;

  function automatic logic [BW-1:0] max2(input logic [BW-1:0] a, input logic [BW-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  // Ties resolve to A, the lower-index subtree, so the lowest index always wins.
  function automatic ent_t combine(input ent_t a, input ent_t b);
    ent_t w, l, r;
    w = a;
    l = b;
    if (b.top > a.top) begin
      w = b;
      l = a;
    end
    r     = w;
    r.sec = max2(l.top, w.sec);
    if (!a.en)      r = b;
    else if (!b.en) r = a;
    return r;
  endfunction

  logic   adv;
  logic   [L:0] vld_p;
  ent_t   leaf_d [NL];
  ent_t   node_p [1:2*NL-1];
  ent_t   root;

  assign adv      = ~vld_p[L] | out_ready;
  assign in_ready = adv;

  for (genvar i = 0; i < NL; i++) begin : g_leaf
    if (i < N_BIDS) begin : g_real
      assign leaf_d[i] = {in_mask[i], IDX_W'(i), in_bids[i*BW +: BW], {BW{1'b0}}};
    end else begin : g_pad
      assign leaf_d[i] = '0;
    end
  end

  // Control path: one valid bit per stage, the only state that reset touches.
  always_ff @(posedge clk) begin
    if (!rst_n)   vld_p <= '0;
    else if (adv) vld_p <= {vld_p[L-1:0], in_valid};
  end

  // Stage 0 holds the leaves (heap slots NL..2NL-1); each tree level is the next stage, root at stage L.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int i = 0; i < NL; i++) node_p[NL+i] <= leaf_d[i];
      for (int n = 1; n < NL; n++) node_p[n] <= combine(node_p[2*n], node_p[2*n+1]);
    end
  end

  assign root      = node_p[1];
  assign out_valid = vld_p[L];

  always_comb begin
    out_none   = 1'b0;
    out_idx    = '0;
    out_max    = '0;
    out_second = '0;
    if (vld_p[L]) begin
      if (root.en) begin
        out_idx    = root.idx;
        out_max    = root.top;
        out_second = root.sec;
      end else begin
        out_none   = 1'b1;
      end
    end
  end

endmodule
